// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
// The accumulator is {hi, lo} for multiply and {remainder, quotient} for divide.
package cpu_pkg;

   localparam int WIDTH      = 16;
   localparam int REG_ADDR_W = 3;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam int ACC_W      = 2 * WIDTH;

   typedef enum logic [1:0] {
      OP_MULL = 2'b00,
      OP_MULH = 2'b01,
      OP_DIV  = 2'b10,
      OP_REM  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply: acc = {hi, lo}. Divide: acc = {partial remainder, dividend/quotient shift register}.
module muldiv_step
   import cpu_pkg::*;
(
   input  logic             i_is_div,
   input  logic [ACC_W-1:0] i_acc,
   input  logic [WIDTH-1:0] i_operand,
   output logic [ACC_W-1:0] o_acc
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH-1:0] w_rem;
   logic             w_ge;

   always_comb begin
      w_sum     = {1'b0, i_acc[ACC_W-1:WIDTH]} + {1'b0, i_operand};
      // The stored remainder is always below the divisor, so 16 bits hold it; the
      // 17th bit only exists transiently after the shift.
      w_shifted = {i_acc[ACC_W-1:WIDTH], i_acc[WIDTH-1]};
      w_ge      = (w_shifted >= {1'b0, i_operand});
      w_rem     = w_shifted[WIDTH-1:0] - i_operand;
      o_acc     = i_acc;
      if (i_is_div) begin
         if (w_ge) begin
            o_acc = {w_rem, i_acc[WIDTH-2:0], 1'b1};
         end else begin
            o_acc = {w_shifted[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
         end
      end else if (i_acc[0]) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[ACC_W-1:WIDTH], i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide with a fixed WIDTH+1 edge latency,
// ending in a single-cycle register file write (wb_en/wb_dest/wb_data).
module muldiv_unit
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  kill,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   input  logic [REG_ADDR_W-1:0] dest,
   output logic                  busy,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_dest,
   output logic [WIDTH-1:0]      wb_data,
   output state_t                dbg_state
);

   // Handshake: start is taken on any edge where busy==0 (state IDLE); the
   // request is dropped, not queued, while busy==1. The result is valid only
   // in the single cycle wb_en==1; wb_dest/wb_data simply hold otherwise.

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_count;
   logic [1:0]            r_op;
   logic [WIDTH-1:0]      r_operand;
   logic [ACC_W-1:0]      r_acc;
   logic [REG_ADDR_W-1:0] r_dest;
   logic                  r_wb_en;
   logic [REG_ADDR_W-1:0] r_wb_dest;
   logic [WIDTH-1:0]      r_wb_data;
   logic [ACC_W-1:0]      w_acc_nxt;
   logic [WIDTH-1:0]      w_result;
   logic                  w_accept;
   logic                  w_last;

   muldiv_step u_step (
      .i_is_div  (r_op[1]),
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .o_acc     (w_acc_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CALC;
         S_CALC: begin
            if (kill) begin
               w_state_nxt = S_IDLE;
            end else if (r_count == CNT_W'(WIDTH - 1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_CALC) && !kill && (r_count == CNT_W'(WIDTH - 1));
   // Low half is the MUL low product or the quotient; high half is MUL high or remainder.
   assign w_result = r_op[0] ? w_acc_nxt[ACC_W-1:WIDTH] : w_acc_nxt[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count   <= '0;
         r_op      <= '0;
         r_operand <= '0;
         r_acc     <= '0;
         r_dest    <= '0;
         r_wb_en   <= 1'b0;
         r_wb_dest <= '0;
         r_wb_data <= '0;
      end else begin
         if (w_accept) begin
            r_op      <= op;
            r_operand <= op[1] ? src_b : src_a;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? src_a : src_b)};
            r_dest    <= dest;
            r_count   <= '0;
         end else if (r_state == S_CALC && !kill) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + CNT_W'(1);
         end
         r_wb_en <= w_last;
         if (w_last) begin
            r_wb_dest <= r_dest;
            r_wb_data <= w_result;
         end
      end
   end

   // A kill raised during DONE suppresses the write already on the port.
   assign wb_en     = r_wb_en & ~kill;
   assign wb_dest   = r_wb_dest;
   assign wb_data   = r_wb_data;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;

endmodule
